// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, functs,
// FSM states, instruction classes and datapath select values.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_LUI   = 2'b10;
    localparam logic [1:0] EXT_SHAMT = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_RS  = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_BRANCH,
        S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_J, CLS_JAL, CLS_JR, CLS_BEQ, CLS_LW, CLS_SW, CLS_ILL
    } cls_e;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: classifies the IR word and produces the
// datapath select fields that stay constant while the instruction is in flight.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output cls_e        cls_o,
    output logic [1:0]  ext_op_o,
    output logic [2:0]  alu_op_o,
    output logic        alu_src_o,
    output logic [1:0]  reg_dst_o,
    output logic [1:0]  wd_sel_o,
    output logic [1:0]  npc_op_o
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];

    always_comb begin
        cls_o     = CLS_ILL;
        ext_op_o  = EXT_SIGN;
        alu_op_o  = ALU_ADD;
        alu_src_o = 1'b0;
        reg_dst_o = DST_RT;
        wd_sel_o  = WD_ALU;
        npc_op_o  = NPC_PC4;
        case (opcode)
            OP_RTYPE: begin
                reg_dst_o = DST_RD;
                case (funct)
                    FN_ADDU: begin cls_o = CLS_ALU; alu_op_o = ALU_ADD; end
                    FN_SUBU: begin cls_o = CLS_ALU; alu_op_o = ALU_SUB; end
                    FN_SLT:  begin cls_o = CLS_ALU; alu_op_o = ALU_SLT; end
                    FN_SLL, FN_SRL: begin
                        // Shift amount travels through the extender as the B operand.
                        cls_o     = CLS_ALU;
                        alu_op_o  = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
                        ext_op_o  = EXT_SHAMT;
                        alu_src_o = 1'b1;
                    end
                    FN_JR:   begin cls_o = CLS_JR; npc_op_o = NPC_RS; end
                    default: cls_o = CLS_ILL;
                endcase
            end
            OP_ADDIU: begin cls_o = CLS_ALU; alu_src_o = 1'b1; end
            OP_ANDI: begin
                cls_o = CLS_ALU; alu_op_o = ALU_AND; ext_op_o = EXT_ZERO; alu_src_o = 1'b1;
            end
            OP_ORI: begin
                cls_o = CLS_ALU; alu_op_o = ALU_OR; ext_op_o = EXT_ZERO; alu_src_o = 1'b1;
            end
            OP_LUI: begin
                cls_o = CLS_ALU; alu_op_o = ALU_OR; ext_op_o = EXT_LUI; alu_src_o = 1'b1;
            end
            OP_LW: begin cls_o = CLS_LW; alu_src_o = 1'b1; wd_sel_o = WD_MEM; end
            OP_SW: begin cls_o = CLS_SW; alu_src_o = 1'b1; end
            OP_BEQ: begin cls_o = CLS_BEQ; alu_op_o = ALU_SUB; npc_op_o = NPC_BR; end
            OP_J:   begin cls_o = CLS_J; npc_op_o = NPC_J; end
            OP_JAL: begin
                cls_o = CLS_JAL; npc_op_o = NPC_J; reg_dst_o = DST_RA; wd_sel_o = WD_PC4;
            end
            default: cls_o = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, generates the
// write strobes and counts retired instructions.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             dm_ready,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic             reg_wr,
    output logic             dm_req,
    output logic             dm_we,
    output logic [1:0]       ext_op,
    output logic [2:0]       alu_op,
    output logic             alu_src,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic [1:0]       npc_op,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    cls_e             cls;
    logic [1:0]       dec_ext_op, dec_reg_dst, dec_wd_sel, dec_npc_op;
    logic [2:0]       dec_alu_op;
    logic             dec_alu_src;
    logic             pc_wr_s, ir_wr_s, reg_wr_s, dm_req_s, dm_we_s, illegal_s, retire;
    logic             sel_en;

    mc_ctrl_decode u_decode (
        .instr_i   (instr),
        .cls_o     (cls),
        .ext_op_o  (dec_ext_op),
        .alu_op_o  (dec_alu_op),
        .alu_src_o (dec_alu_src),
        .reg_dst_o (dec_reg_dst),
        .wd_sel_o  (dec_wd_sel),
        .npc_op_o  (dec_npc_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_wr_s   = 1'b0;
        ir_wr_s   = 1'b0;
        reg_wr_s  = 1'b0;
        dm_req_s  = 1'b0;
        dm_we_s   = 1'b0;
        illegal_s = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_wr_s = 1'b1;
                pc_wr_s = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (cls)
                    CLS_J, CLS_JR: begin pc_wr_s = 1'b1; retire = 1'b1; end
                    CLS_JAL: begin pc_wr_s = 1'b1; reg_wr_s = 1'b1; retire = 1'b1; end
                    CLS_BEQ: state_d = S_BRANCH;
                    CLS_LW, CLS_SW: state_d = S_MEMADR;
                    CLS_ALU: state_d = S_EXEC;
                    default: begin illegal_s = 1'b1; retire = 1'b1; end
                endcase
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  begin reg_wr_s = 1'b1; retire = 1'b1; end
            S_BRANCH: begin pc_wr_s = zero; retire = 1'b1; end
            S_MEMADR: state_d = (cls == CLS_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                dm_req_s = 1'b1;
                if (dm_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                dm_req_s = 1'b1;
                dm_we_s  = 1'b1;
                retire   = dm_ready;
            end
            S_MEMWB:  begin reg_wr_s = 1'b1; retire = 1'b1; end
            default:  state_d = S_FETCH;
        endcase
        if (retire) state_d = S_FETCH;
    end

    // State resets to FETCH, whose strobes are active; rst_n masks them so
    // nothing writes while reset is held, and drops dm_req the instant it asserts.
    assign pc_wr   = rst_n & pc_wr_s;
    assign ir_wr   = rst_n & ir_wr_s;
    assign reg_wr  = rst_n & reg_wr_s;
    assign dm_req  = rst_n & dm_req_s;
    assign dm_we   = rst_n & dm_we_s;
    assign illegal = rst_n & illegal_s;

    // In FETCH the IR still holds the previous word, so selects are forced to 0.
    assign sel_en  = rst_n && (state_q != S_FETCH);
    assign ext_op  = sel_en ? dec_ext_op  : 2'b00;
    assign alu_op  = sel_en ? dec_alu_op  : 3'b000;
    assign alu_src = sel_en ? dec_alu_src : 1'b0;
    assign reg_dst = sel_en ? dec_reg_dst : 2'b00;
    assign wd_sel  = sel_en ? dec_wd_sel  : 2'b00;
    assign npc_op  = sel_en ? dec_npc_op  : 2'b00;

    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks ori, lw with memory wait, beq taken/not taken,
// sll, jal, an illegal opcode and a reset during a store.
module tb_mc_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        dm_ready;
    logic        pc_wr, ir_wr, reg_wr, dm_req, dm_we, alu_src, illegal;
    logic [1:0]  ext_op, reg_dst, wd_sel, npc_op;
    logic [2:0]  alu_op;
    logic [31:0] instr_cnt;

    int checks = 0;
    int errors = 0;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .zero      (zero),
        .dm_ready  (dm_ready),
        .pc_wr     (pc_wr),
        .ir_wr     (ir_wr),
        .reg_wr    (reg_wr),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .ext_op    (ext_op),
        .alu_op    (alu_op),
        .alu_src   (alu_src),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .npc_op    (npc_op),
        .illegal   (illegal),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are checked at the negedge; this moves to the next cycle's negedge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; instr = 32'h0; zero = 1'b0; dm_ready = 1'b0;
        repeat (3) next_cycle();
        check("rst_pc_wr",  {31'b0, pc_wr},  32'd0);
        check("rst_ir_wr",  {31'b0, ir_wr},  32'd0);
        check("rst_reg_wr", {31'b0, reg_wr}, 32'd0);
        check("rst_dm_req", {31'b0, dm_req}, 32'd0);
        check("rst_cnt",    instr_cnt,       32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ir_wr", {31'b0, ir_wr}, 32'd1);
        check("rel_pc_wr", {31'b0, pc_wr}, 32'd1);
        check("rel_npc",   {30'b0, npc_op}, 32'd0);

        // ori $1,$0,0x8000 : FETCH, DECODE, EXEC, ALUWB
        instr = 32'h3401_8000;
        next_cycle();
        check("ori_ext",     {30'b0, ext_op}, 32'd1);
        check("ori_alu",     {29'b0, alu_op}, 32'd2);
        check("ori_src",     {31'b0, alu_src}, 32'd1);
        check("ori_dec_wr",  {31'b0, reg_wr}, 32'd0);
        next_cycle();
        check("ori_exec_wr", {31'b0, reg_wr}, 32'd0);
        next_cycle();
        check("ori_wb_wr",   {31'b0, reg_wr}, 32'd1);
        check("ori_wb_dst",  {30'b0, reg_dst}, 32'd0);
        check("ori_wb_wd",   {30'b0, wd_sel}, 32'd0);
        next_cycle();
        check("ori_cnt",     instr_cnt, 32'd1);
        check("ori_fetch",   {31'b0, ir_wr}, 32'd1);

        // lw $2,4($0) with dm_ready low for 3 cycles: 8 cycles total
        instr = 32'h8C02_0004;
        next_cycle();
        check("lw_dec_wd", {30'b0, wd_sel}, 32'd1);
        next_cycle();
        check("lw_adr_alu", {29'b0, alu_op}, 32'd0);
        check("lw_adr_src", {31'b0, alu_src}, 32'd1);
        check("lw_adr_req", {31'b0, dm_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check($sformatf("lw_req%0d", i), {31'b0, dm_req}, 32'd1);
            check($sformatf("lw_we%0d", i),  {31'b0, dm_we},  32'd0);
            check($sformatf("lw_wr%0d", i),  {31'b0, reg_wr}, 32'd0);
            if (i == 3) dm_ready = 1'b1;
        end
        next_cycle();
        dm_ready = 1'b0;
        check("lw_wb_wr",  {31'b0, reg_wr}, 32'd1);
        check("lw_wb_wd",  {30'b0, wd_sel}, 32'd1);
        check("lw_wb_dst", {30'b0, reg_dst}, 32'd0);
        check("lw_wb_req", {31'b0, dm_req}, 32'd0);
        next_cycle();
        check("lw_cnt",   instr_cnt, 32'd2);
        check("lw_fetch", {31'b0, ir_wr}, 32'd1);

        // beq taken then not taken: 3 cycles each
        for (int t = 1; t >= 0; t--) begin
            instr = 32'h1022_0003;
            next_cycle();
            check($sformatf("beq%0d_dec_alu", t), {29'b0, alu_op}, 32'd1);
            check($sformatf("beq%0d_dec_pc", t),  {31'b0, pc_wr}, 32'd0);
            zero = (t == 1);
            next_cycle();
            #1;
            check($sformatf("beq%0d_pc_wr", t), {31'b0, pc_wr}, t);
            check($sformatf("beq%0d_npc", t),   {30'b0, npc_op}, 32'd1);
            next_cycle();
            zero = 1'b0;
            check($sformatf("beq%0d_fetch", t), {31'b0, ir_wr}, 32'd1);
        end
        check("beq_cnt", instr_cnt, 32'd4);

        // sll $2,$3,5
        instr = 32'h0003_1140;
        next_cycle();
        check("sll_ext", {30'b0, ext_op}, 32'd3);
        check("sll_alu", {29'b0, alu_op}, 32'd5);
        check("sll_src", {31'b0, alu_src}, 32'd1);
        next_cycle();
        next_cycle();
        check("sll_wb_wr",  {31'b0, reg_wr}, 32'd1);
        check("sll_wb_dst", {30'b0, reg_dst}, 32'd1);
        next_cycle();
        check("sll_cnt", instr_cnt, 32'd5);

        // jal: writes $31 with PC+4 in DECODE, retires in 2 cycles
        instr = 32'h0C00_0010;
        next_cycle();
        check("jal_wr",  {31'b0, reg_wr}, 32'd1);
        check("jal_pc",  {31'b0, pc_wr}, 32'd1);
        check("jal_dst", {30'b0, reg_dst}, 32'd2);
        check("jal_wd",  {30'b0, wd_sel}, 32'd2);
        check("jal_npc", {30'b0, npc_op}, 32'd2);
        next_cycle();
        check("jal_cnt",   instr_cnt, 32'd6);
        check("jal_fetch", {31'b0, ir_wr}, 32'd1);

        // Unsupported opcode 6'h3f
        instr = 32'hFC00_0000;
        next_cycle();
        check("ill_pulse",  {31'b0, illegal}, 32'd1);
        check("ill_reg_wr", {31'b0, reg_wr}, 32'd0);
        check("ill_dm_req", {31'b0, dm_req}, 32'd0);
        check("ill_pc_wr",  {31'b0, pc_wr}, 32'd0);
        next_cycle();
        check("ill_clear", {31'b0, illegal}, 32'd0);
        check("ill_cnt",   instr_cnt, 32'd7);

        // sw $2,8($0), then reset asserted while waiting in MEMWR
        instr = 32'hAC02_0008;
        next_cycle();
        next_cycle();
        next_cycle();
        check("sw_req", {31'b0, dm_req}, 32'd1);
        check("sw_we",  {31'b0, dm_we}, 32'd1);
        next_cycle();
        check("sw_wait_req", {31'b0, dm_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("sw_rst_req", {31'b0, dm_req}, 32'd0);
        check("sw_rst_we",  {31'b0, dm_we}, 32'd0);
        check("sw_rst_cnt", instr_cnt, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        #1;
        check("sw_rel_ir_wr", {31'b0, ir_wr}, 32'd1);
        check("sw_rel_req",   {31'b0, dm_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
